gated_residual_unit: RTL and testbench

GATED_RESIDUAL_UNIT -- requirements
Module: gated_residual_unit

---
 rtl/gated_residual_unit_pkg.sv | 34 +++
 rtl/gated_residual_unit_if.sv | 23 ++
 rtl/gated_act_lut.sv | 17 +
 rtl/gated_residual_unit.sv | 111 +++++++++++
 tb/tb_gated_residual_unit.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/gated_residual_unit_pkg.sv
// Shared constants, types and saturation helpers for the gated residual unit.
// All fixed-point values are Q1.6 / Q0.6 with 64 representing 1.0.
package gated_residual_unit_pkg;

  localparam int ONE_Q6     = 64;
  localparam int SIG_OFFSET = 32;
  localparam int TANH_MIN   = -ONE_Q6;
  localparam int TANH_MAX   = ONE_Q6;
  localparam int SIG_MIN    = 0;
  localparam int SIG_MAX    = ONE_Q6;
  localparam int SAT8_MIN   = -128;
  localparam int SAT8_MAX   = 127;
  localparam int SAT16_MIN  = -32768;
  localparam int SAT16_MAX  = 32767;

  typedef logic signed [7:0]  sample_t;
  typedef logic signed [13:0] prod_t;
  typedef logic signed [15:0] acc_t;

  function automatic int clamp(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic sample_t sat8(input logic signed [8:0] v);
    return sample_t'(clamp(int'(v), SAT8_MIN, SAT8_MAX));
  endfunction

  function automatic acc_t sat16(input logic signed [16:0] v);
    return acc_t'(clamp(int'(v), SAT16_MIN, SAT16_MAX));
  endfunction

endpackage

// File: rtl/gated_residual_unit_if.sv
// Sample-in / result-out bundle of the gated residual unit.
// The master side feeds samples; the slave side is the unit itself.
interface gated_residual_unit_if;
  logic                                   in_valid;
  gated_residual_unit_pkg::sample_t       f;
  gated_residual_unit_pkg::sample_t       g;
  gated_residual_unit_pkg::sample_t       x_res;
  logic                                   out_valid;
  gated_residual_unit_pkg::sample_t       y_res;
  gated_residual_unit_pkg::sample_t       z_out;
  gated_residual_unit_pkg::acc_t          skip_out;
  logic                                   skip_done;

  modport master (
    output in_valid, f, g, x_res,
    input  out_valid, y_res, z_out, skip_out, skip_done
  );

  modport slave (
    input  in_valid, f, g, x_res,
    output out_valid, y_res, z_out, skip_out, skip_done
  );
endinterface

// File: rtl/gated_act_lut.sv
// Hard-tanh of the filter path and hard-sigmoid of the gate path, purely
// combinational; the arithmetic shift on g floors toward minus infinity.
module gated_act_lut
  import gated_residual_unit_pkg::*;
(
  input  sample_t f_i,
  input  sample_t g_i,
  output sample_t t_o,
  output sample_t s_o
);

  always_comb begin
    t_o = sample_t'(clamp(int'(f_i), TANH_MIN, TANH_MAX));
    s_o = sample_t'(clamp(int'(g_i >>> 2) + SIG_OFFSET, SIG_MIN, SIG_MAX));
  end

endmodule

// File: rtl/gated_residual_unit.sv
// Three-stage gated activation with residual add and a windowed skip-sum
// accumulator; no backpressure, one sample per cycle.
module gated_residual_unit
  import gated_residual_unit_pkg::*;
#(
  parameter int unsigned SKIP_LEN = 16
) (
  input logic                  clk,
  input logic                  reset,
  gated_residual_unit_if.slave bus
);

  sample_t t_d, s_d;
  sample_t t_q, s_q, x1_q;
  logic    v1_q;

  prod_t   prod_d, prod_q;
  sample_t x2_q;
  logic    v2_q;

  sample_t z_d, y_d, z_q, y_q;
  logic    v3_q;

  acc_t       acc_d, acc_q, skip_d, skip_q;
  logic [7:0] cnt_d, cnt_q;
  logic       done_d, done_q;
  acc_t       acc_sat;
  logic       window_end;

  gated_act_lut u_act (
    .f_i (bus.f),
    .g_i (bus.g),
    .t_o (t_d),
    .s_o (s_d)
  );

  always_comb begin
    prod_d     = 14'(t_q) * 14'(s_q);
    z_d        = sample_t'(prod_q >>> 6);
    y_d        = sat8(9'(x2_q) + 9'(z_d));
    acc_sat    = sat16(17'(acc_q) + 17'(z_d));
    window_end = (({1'b0, cnt_q} + 9'd1) == 9'(SKIP_LEN));
  end

  // The skip window accumulates on the same edge S3 loads, so skip_done
  // coincides with out_valid of the window's last sample.
  always_comb begin
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    skip_d = skip_q;
    done_d = 1'b0;
    if (v2_q) begin
      if (window_end) begin
        skip_d = acc_sat;
        done_d = 1'b1;
        acc_d  = '0;
        cnt_d  = '0;
      end else begin
        acc_d = acc_sat;
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q   <= 1'b0;
      t_q    <= '0;
      s_q    <= '0;
      x1_q   <= '0;
      v2_q   <= 1'b0;
      prod_q <= '0;
      x2_q   <= '0;
      v3_q   <= 1'b0;
      z_q    <= '0;
      y_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      skip_q <= '0;
      done_q <= 1'b0;
    end else begin
      v1_q <= bus.in_valid;
      if (bus.in_valid) begin
        t_q  <= t_d;
        s_q  <= s_d;
        x1_q <= bus.x_res;
      end
      v2_q <= v1_q;
      if (v1_q) begin
        prod_q <= prod_d;
        x2_q   <= x1_q;
      end
      v3_q <= v2_q;
      if (v2_q) begin
        z_q <= z_d;
        y_q <= y_d;
      end
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      skip_q <= skip_d;
      done_q <= done_d;
    end
  end

  assign bus.out_valid = v3_q;
  assign bus.z_out     = z_q;
  assign bus.y_res     = y_q;
  assign bus.skip_out  = skip_q;
  assign bus.skip_done = done_q;

endmodule

// File: tb/tb_gated_residual_unit.sv
// Self-checking bench: fixed vectors, windowed corner sequences and random
// traffic against a cycle-agnostic scoreboard, on SKIP_LEN=4 and SKIP_LEN=1.
module tb_gated_residual_unit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  gated_residual_unit_if bus4 ();
  gated_residual_unit_if bus1 ();

  assign bus1.in_valid = bus4.in_valid;
  assign bus1.f        = bus4.f;
  assign bus1.g        = bus4.g;
  assign bus1.x_res    = bus4.x_res;

  gated_residual_unit #(.SKIP_LEN(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));
  gated_residual_unit #(.SKIP_LEN(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  int cmp_cnt = 0;
  int err_cnt = 0;
  int edge_n  = 0;

  typedef struct {int due; int z; int y;} exp_t;
  exp_t q[$];

  int ez, ey, eov;
  int lens[2]  = '{4, 1};
  int eacc[2]  = '{0, 0};
  int ecnt[2]  = '{0, 0};
  int eskip[2] = '{0, 0};
  int edone[2] = '{0, 0};

  function automatic int lim(input int v, input int lo, input int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  function automatic int fdiv(input int a, input int b);
    int r = a / b;
    if ((a % b) != 0 && a < 0) r = r - 1;
    return r;
  endfunction

  function automatic int model_z(input int fv, input int gv);
    int t = lim(fv, -64, 64);
    int s = lim(fdiv(gv, 4) + 32, 0, 64);
    return fdiv(t * s, 64);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    cmp_cnt++;
    if (act != exp) begin
      err_cnt++;
      $display("FAIL %s @edge %0d: got %0d, expected %0d", name, edge_n, act, exp);
    end
  endtask

  task automatic model_edge(input logic rst, input logic v, input int fv, input int gv,
                            input int xv);
    int z;
    eov = 0;
    for (int i = 0; i < 2; i++) edone[i] = 0;
    if (rst) begin
      q.delete();
      ez = 0; ey = 0;
      for (int i = 0; i < 2; i++) begin
        eacc[i] = 0; ecnt[i] = 0; eskip[i] = 0;
      end
      return;
    end
    if (v) begin
      z = model_z(fv, gv);
      q.push_back('{due: edge_n + 2, z: z, y: lim(xv + z, -128, 127)});
    end
    if (q.size() > 0 && q[0].due == edge_n) begin
      exp_t e = q.pop_front();
      eov = 1; ez = e.z; ey = e.y;
      for (int i = 0; i < 2; i++) begin
        eacc[i] = lim(eacc[i] + e.z, -32768, 32767);
        ecnt[i]++;
        if (ecnt[i] == lens[i]) begin
          eskip[i] = eacc[i]; edone[i] = 1; eacc[i] = 0; ecnt[i] = 0;
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("out_valid", bus4.out_valid, eov);
    chk("z_out", bus4.z_out, ez);
    chk("y_res", bus4.y_res, ey);
    chk("skip_out4", bus4.skip_out, eskip[0]);
    chk("skip_done4", bus4.skip_done, edone[0]);
    chk("skip_out1", bus1.skip_out, eskip[1]);
    chk("skip_done1", bus1.skip_done, edone[1]);
    chk("out_valid1", bus1.out_valid, eov);
  endtask

  task automatic step(input logic rst, input logic v, input int fv, input int gv, input int xv);
    reset         = rst;
    bus4.in_valid = v;
    bus4.f        = 8'(fv);
    bus4.g        = 8'(gv);
    bus4.x_res    = 8'(xv);
    @(posedge clk);
    edge_n++;
    model_edge(rst, v, fv, gv, xv);
    #1;
    compare_all();
  endtask

  typedef struct {int f; int g; int x; int z; int y;} vec_t;
  vec_t vecs[7];

  int pulses, sv, ovs;

  initial begin
    vecs[0] = '{f: 64,   g: 127,  x: 10,   z: 63,  y: 73};
    vecs[1] = '{f: -128, g: 127,  x: -100, z: -63, y: -128};
    vecs[2] = '{f: 127,  g: 127,  x: 100,  z: 63,  y: 127};
    vecs[3] = '{f: 100,  g: -128, x: -5,   z: 0,   y: -5};
    vecs[4] = '{f: 32,   g: 0,    x: 0,    z: 16,  y: 16};
    vecs[5] = '{f: -1,   g: -1,   x: 0,    z: -1,  y: -1};
    vecs[6] = '{f: 64,   g: -4,   x: 127,  z: 31,  y: 127};

    step(1, 0, 0, 0, 0);
    step(1, 1, 64, 127, 10);
    chk("rst_out_valid", bus4.out_valid, 0);
    chk("rst_skip_out", bus4.skip_out, 0);

    for (int i = 0; i < 7; i++) begin
      step(0, 1, vecs[i].f, vecs[i].g, vecs[i].x);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      chk("tbl_valid", bus4.out_valid, 1);
      chk("tbl_z", bus4.z_out, vecs[i].z);
      chk("tbl_y", bus4.y_res, vecs[i].y);
    end

    // Two full windows of +63 then -63.
    step(1, 0, 0, 0, 0);
    for (int w = 0; w < 2; w++) begin
      pulses = 0; sv = 0;
      for (int i = 0; i < 7; i++) begin
        if (i < 4) step(0, 1, (w == 0) ? 64 : -128, 127, 0);
        else       step(0, 0, 0, 0, 0);
        if (bus4.skip_done) begin pulses++; sv = bus4.skip_out; end
      end
      chk("win_pulses", pulses, 1);
      chk("win_sum", sv, (w == 0) ? 252 : -252);
    end
    step(0, 0, 0, 0, 0);
    chk("skip_hold", bus4.skip_out, -252);

    // Valid pattern 1,0,1 with y_res held in the gap.
    step(0, 1, 64, 127, 10);
    step(0, 0, 0, 0, 0);
    step(0, 1, 32, 0, 0);
    chk("gap_v0", bus4.out_valid, 1);
    chk("gap_y0", bus4.y_res, 73);
    step(0, 0, 0, 0, 0);
    chk("gap_v1", bus4.out_valid, 0);
    chk("gap_hold", bus4.y_res, 73);
    step(0, 0, 0, 0, 0);
    chk("gap_v2", bus4.out_valid, 1);
    chk("gap_y2", bus4.y_res, 16);

    // Reset mid-window: only post-reset samples reach the skip sum.
    step(1, 0, 0, 0, 0);
    step(0, 1, 64, 127, 0);
    step(0, 1, 64, 127, 0);
    step(1, 1, 64, 127, 0);
    pulses = 0; sv = 0; ovs = 0;
    for (int i = 0; i < 8; i++) begin
      if (i < 4) step(0, 1, 32, 0, 0);
      else       step(0, 0, 0, 0, 0);
      if (bus4.out_valid) ovs++;
      if (bus4.skip_done) begin pulses++; sv = bus4.skip_out; end
    end
    chk("rst_win_outs", ovs, 4);
    chk("rst_win_pulses", pulses, 1);
    chk("rst_win_sum", sv, 64);

    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0),
           int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
           int'($urandom_range(0, 255)) - 128);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
